bist_controller: RTL and testbench
==================================

// Module: bist_controller
// PURPOSE
//  Sequencer for the multiplier BIST loop. Drives the pattern generator (TPG) and the
//  signature register's shift/clear. Counts applied patterns and compensates CUT latency.
//  Compares the final 8-bit MISR signature against a golden value and reports pass/fail.
//  Sits between the test-access/start logic and the TPG -> CUT -> MISR datapath.
// PARAMETERS
//  N_PATTERNS   255    patterns applied per run (>=1, <= 2**CNT_W-1)
//  CNT_W        8      pattern counter width
//  CUT_LATENCY  1      cycles from tpg_en to valid CUT product at MISR d (0..7)
//  GOLDEN_SIG   8'h00  expected signature; overridden per build from the golden model
// PORTS
//  clk          in   1      clock, rising edge
//  reset_b      in   1      asynchronous, active-low reset
//  start        in   1      run request; sampled in IDLE/DONE only
//  abort        in   1      abandon run, return to IDLE
//  sig          in   8      current MISR signature
//  tpg_load     out  1      load seed into TPG (1 cycle)
//  tpg_en       out  1      TPG advance / pattern valid
//  misr_rst_b   out  1      registered active-low clear to MISR (glitch-free)
//  misr_shift   out  1      MISR shift enable (tpg_en delayed CUT_LATENCY)
//  pat_cnt      out  CNT_W  patterns applied in current run
//  busy         out  1      high in SEED/RUN/DRAIN/CHECK
//  done         out  1      high in DONE
//  pass         out  1      sig==GOLDEN_SIG at CHECK; valid while done
// BEHAVIOUR
//  Reset: state=IDLE; tpg_load=tpg_en=misr_shift=busy=done=pass=0; misr_rst_b=1; pat_cnt=0;
//    delay line cleared. All outputs registered.
//  IDLE : start -> SEED.
//  SEED : 1 cycle; tpg_load=1, misr_rst_b=0, pat_cnt<=0 -> RUN.
//  RUN  : tpg_en=1; pat_cnt++ each cycle; on pat_cnt==N_PATTERNS-1 -> DRAIN
//    (exactly N_PATTERNS cycles of tpg_en).
//  DRAIN: tpg_en=0; stay CUT_LATENCY cycles (0 => skip straight to CHECK) until
//    the delay line is empty.
//  CHECK: 1 cycle; pass<=(sig==GOLDEN_SIG) -> DONE.
//  DONE : done=1, pass held, pat_cnt held at N_PATTERNS; start -> SEED (rerun, pass cleared).
//  misr_shift = tpg_en delayed CUT_LATENCY cycles. Total misr_shift cycles == N_PATTERNS.
//  start while busy: ignored. abort (any state) -> IDLE next cycle, pass=0, done=0,
//    delay line flushed, misr_shift=0; abort beats start if both high.
//  pat_cnt never wraps; it saturates at N_PATTERNS.
// CONFIGURATION
//  BIST_SIG_CAPTURE_EN defined:
//    - adds output sig_cap[7:0], reset 0, loaded with sig in CHECK, held until next SEED (diagnosis).
//  Undefined: port and register absent; all other behaviour identical.
// STRUCTURE
//  bist_pkg: SIG_W=8; MISR_POLY=8'h1D (x^8+x^4+x^3+x^2+1); typedef enum state_t
//    {IDLE,SEED,RUN,DRAIN,CHECK,DONE}.
//  Sub-module bist_shift_delay: parameterised DEPTH=CUT_LATENCY delay line with
//    sync flush; DEPTH=0 is a wire.
// TESTING (N_PATTERNS=4, CUT_LATENCY=2 unless noted)
//  1 Reset mid-RUN -> all outputs at reset values immediately, misr_rst_b=1, state IDLE.
//  2 start pulse in IDLE -> SEED 1 cyc (misr_rst_b=0, tpg_load=1); tpg_en 4 cyc;
//    misr_shift 4 cyc starting 2 cyc after tpg_en; done rises 8 cyc after SEED; pat_cnt=4.
//  3 sig driven =GOLDEN_SIG (8'h5A) at CHECK -> pass=1; sig=8'h5B -> pass=0; done=1 both.
//  4 abort on 2nd RUN cycle -> IDLE next cycle, tpg_en=0, misr_shift=0 same cycle, no done.
//  5 start held high during RUN -> no restart; start in DONE -> new SEED, pass cleared.
//  6 CUT_LATENCY=0 -> misr_shift coincident with tpg_en, DRAIN skipped;
//    with BIST_SIG_CAPTURE_EN sig_cap==sig at CHECK.

Source files
------------

// File: rtl/bist_pkg.sv
// ----------------------------------------------------------------------------
// bist_pkg : shared types and constants for the multiplier BIST slice
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bist_pkg;
  localparam int SIG_W = 8;
  // x^8 + x^4 + x^3 + x^2 + 1, the MISR feedback used by the golden model
  localparam logic [SIG_W-1:0] MISR_POLY = 8'h1D;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == SEED) || (s == RUN) || (s == DRAIN) || (s == CHECK);
  endfunction
endpackage

`default_nettype wire

// File: rtl/bist_if.sv
// ----------------------------------------------------------------------------
// bist_if : controller <-> TPG/CUT/MISR datapath signals
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bist_if;
  import bist_pkg::*;

  logic             tpg_load;
  logic             tpg_en;
  logic             misr_rst_b;
  logic             misr_shift;
  logic [SIG_W-1:0] sig;

  modport master (output tpg_load, output tpg_en, output misr_rst_b,
                  output misr_shift, input sig);
  modport slave  (input tpg_load, input tpg_en, input misr_rst_b,
                  input misr_shift, output sig);
endinterface

`default_nettype wire

// File: rtl/bist_shift_delay.sv
// ----------------------------------------------------------------------------
// bist_shift_delay : DEPTH-cycle delay line with synchronous flush; DEPTH=0 is a wire
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bist_shift_delay #(
  parameter int DEPTH = 1
) (
  input  wire  clk,
  input  wire  reset_b,
  input  wire  flush,
  input  wire  d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = ^{clk, reset_b, flush};
      assign q = d;
    end else begin : g_line
      logic [DEPTH-1:0] line_q, line_d;

      always_comb begin
        line_d = flush ? '0 : DEPTH'({line_q, d});
      end

      always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) line_q <= '0;
        else          line_q <= line_d;
      end

      assign q = line_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/bist_controller.sv
// ----------------------------------------------------------------------------
// bist_controller : multiplier BIST sequencer - seeds TPG, runs N patterns,
// drains CUT latency, compares MISR signature with GOLDEN_SIG.
// Option BIST_SIG_CAPTURE_EN adds the sig_cap diagnostic output.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bist_controller
  import bist_pkg::*;
#(
  parameter int               N_PATTERNS  = 255,
  parameter int               CNT_W       = 8,
  parameter int               CUT_LATENCY = 1,
  parameter logic [SIG_W-1:0] GOLDEN_SIG  = 8'h00
) (
  input  wire              clk,
  input  wire              reset_b,
  input  wire              start,
  input  wire              abort,
  bist_if.master           dp,
  output logic [CNT_W-1:0] pat_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass
`ifdef BIST_SIG_CAPTURE_EN
  , output logic [SIG_W-1:0] sig_cap
`endif
);

  localparam logic [CNT_W-1:0] PAT_LAST   = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] PAT_MAX    = CNT_W'(N_PATTERNS);
  localparam logic [2:0]       DRAIN_LAST = 3'(CUT_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [2:0]       drain_q, drain_d;
  logic             tpg_load_q, tpg_load_d;
  logic             tpg_en_q, tpg_en_d;
  logic             misr_rst_b_q, misr_rst_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             misr_shift_w;

  always_comb begin
    state_d   = state_q;
    pat_cnt_d = pat_cnt_q;
    drain_d   = drain_q;
    pass_d    = pass_q;

    unique case (state_q)
      IDLE:  if (start) state_d = SEED;
      SEED: begin
        state_d   = RUN;
        pat_cnt_d = '0;
      end
      RUN: begin
        if (pat_cnt_q != PAT_MAX) pat_cnt_d = pat_cnt_q + 1'b1;
        if (pat_cnt_q == PAT_LAST) begin
          state_d = (CUT_LATENCY == 0) ? CHECK : DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == DRAIN_LAST) state_d = CHECK;
      end
      CHECK: begin
        state_d = DONE;
        pass_d  = (dp.sig == GOLDEN_SIG);
      end
      DONE:    if (start) state_d = SEED;
      default: state_d = IDLE;
    endcase

    if (state_d == SEED) pass_d = 1'b0;

    // abort wins over everything, including a simultaneous start
    if (abort) begin
      state_d   = IDLE;
      pass_d    = 1'b0;
      pat_cnt_d = '0;
    end

    // outputs are decoded from the next state so they leave the flops glitch-free
    tpg_load_d   = (state_d == SEED);
    tpg_en_d     = (state_d == RUN);
    misr_rst_b_d = (state_d != SEED);
    busy_d       = is_busy(state_d);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= IDLE;
      pat_cnt_q    <= '0;
      drain_q      <= '0;
      tpg_load_q   <= 1'b0;
      tpg_en_q     <= 1'b0;
      misr_rst_b_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_cnt_q    <= pat_cnt_d;
      drain_q      <= drain_d;
      tpg_load_q   <= tpg_load_d;
      tpg_en_q     <= tpg_en_d;
      misr_rst_b_q <= misr_rst_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  bist_shift_delay #(
    .DEPTH (CUT_LATENCY)
  ) u_shift_delay (
    .clk     (clk),
    .reset_b (reset_b),
    .flush   (abort),
    .d       (tpg_en_q),
    .q       (misr_shift_w)
  );

`ifdef BIST_SIG_CAPTURE_EN
  logic [SIG_W-1:0] sig_cap_q, sig_cap_d;

  always_comb begin
    sig_cap_d = sig_cap_q;
    if (state_q == CHECK)  sig_cap_d = dp.sig;
    if (state_d == SEED)   sig_cap_d = '0;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) sig_cap_q <= '0;
    else          sig_cap_q <= sig_cap_d;
  end

  assign sig_cap = sig_cap_q;
`endif

  assign dp.tpg_load   = tpg_load_q;
  assign dp.tpg_en     = tpg_en_q;
  assign dp.misr_rst_b = misr_rst_b_q;
  assign dp.misr_shift = misr_shift_w;
  assign pat_cnt       = pat_cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_controller.sv
// ----------------------------------------------------------------------------
// tb_bist_controller : two controllers (CUT_LATENCY 2 and 0) under random runs,
// aborts and a mid-run reset, checked by a per-run scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bist_controller;
  import bist_pkg::*;

  localparam int         N  = 4;
  localparam int         L0 = 2;
  localparam int         L1 = 0;
  localparam logic [7:0] G0 = 8'h5A;
  localparam logic [7:0] G1 = 8'hC3;

  typedef struct {
    logic       pass;
    logic [7:0] sig;
  } exp_t;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  bist_if dp0 ();
  bist_if dp1 ();

  logic [7:0] pat_cnt0, pat_cnt1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
`ifdef BIST_SIG_CAPTURE_EN
  logic [7:0] sig_cap0, sig_cap1;
`endif

  bist_controller #(.N_PATTERNS(N), .CNT_W(8), .CUT_LATENCY(L0), .GOLDEN_SIG(G0)) u_dut0 (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort), .dp(dp0),
    .pat_cnt(pat_cnt0), .busy(busy0), .done(done0), .pass(pass0)
`ifdef BIST_SIG_CAPTURE_EN
    , .sig_cap(sig_cap0)
`endif
  );

  bist_controller #(.N_PATTERNS(N), .CNT_W(8), .CUT_LATENCY(L1), .GOLDEN_SIG(G1)) u_dut1 (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort), .dp(dp1),
    .pat_cnt(pat_cnt1), .busy(busy1), .done(done1), .pass(pass1)
`ifdef BIST_SIG_CAPTURE_EN
    , .sig_cap(sig_cap1)
`endif
  );

  always #5 clk = ~clk;

  // per-DUT views so the checker can loop
  logic       ld_o [2], en_o [2], rst_o [2], sh_o [2], busy_o [2], done_o [2], pass_o [2];
  logic [7:0] cnt_o [2], cap_o [2];
  assign ld_o[0] = dp0.tpg_load;    assign ld_o[1] = dp1.tpg_load;
  assign en_o[0] = dp0.tpg_en;      assign en_o[1] = dp1.tpg_en;
  assign rst_o[0] = dp0.misr_rst_b; assign rst_o[1] = dp1.misr_rst_b;
  assign sh_o[0] = dp0.misr_shift;  assign sh_o[1] = dp1.misr_shift;
  assign busy_o[0] = busy0;         assign busy_o[1] = busy1;
  assign done_o[0] = done0;         assign done_o[1] = done1;
  assign pass_o[0] = pass0;         assign pass_o[1] = pass1;
  assign cnt_o[0] = pat_cnt0;       assign cnt_o[1] = pat_cnt1;
`ifdef BIST_SIG_CAPTURE_EN
  assign cap_o[0] = sig_cap0;       assign cap_o[1] = sig_cap1;
`else
  assign cap_o[0] = 8'h00;          assign cap_o[1] = 8'h00;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int lat_of(int d);
    return (d == 0) ? L0 : L1;
  endfunction

  function automatic logic [7:0] pick_sig(logic [7:0] g);
    case ($urandom_range(0, 2))
      0:       return g;
      1:       return g ^ 8'h01;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic chk_quiet(input string tag, input bit with_cnt);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_tpg_load", tag, d), 32'(ld_o[d]), 32'd0);
      chk($sformatf("%s_d%0d_tpg_en", tag, d), 32'(en_o[d]), 32'd0);
      chk($sformatf("%s_d%0d_misr_shift", tag, d), 32'(sh_o[d]), 32'd0);
      chk($sformatf("%s_d%0d_misr_rst_b", tag, d), 32'(rst_o[d]), 32'd1);
      chk($sformatf("%s_d%0d_busy", tag, d), 32'(busy_o[d]), 32'd0);
      chk($sformatf("%s_d%0d_done", tag, d), 32'(done_o[d]), 32'd0);
      chk($sformatf("%s_d%0d_pass", tag, d), 32'(pass_o[d]), 32'd0);
      if (with_cnt) chk($sformatf("%s_d%0d_pat_cnt", tag, d), 32'(cnt_o[d]), 32'd0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: tracks each run from its seed pulse and scores it when done rises
  int   seed_cyc [2], en_cnt [2], sh_cnt [2], first_en [2], first_sh [2];
  logic done_prev [2];
  exp_t e_m;
  bit   have_e;

  initial begin
    for (int d = 0; d < 2; d++) done_prev[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!reset_b) begin
          done_prev[d] = 1'b0;
        end else begin
          if (ld_o[d]) begin
            chk($sformatf("seed_d%0d_misr_rst_b", d), 32'(rst_o[d]), 32'd0);
            chk($sformatf("seed_d%0d_pass_cleared", d), 32'(pass_o[d] | done_o[d]), 32'd0);
            seed_cyc[d] = cyc;
            en_cnt[d]   = 0;
            sh_cnt[d]   = 0;
            first_en[d] = -1;
            first_sh[d] = -1;
          end
          if (en_o[d]) begin
            if (first_en[d] < 0) first_en[d] = cyc;
            en_cnt[d]++;
          end
          if (sh_o[d]) begin
            if (first_sh[d] < 0) first_sh[d] = cyc;
            sh_cnt[d]++;
          end
          if (done_o[d] && !done_prev[d]) begin
            have_e = 1'b0;
            if (d == 0 && q0.size() > 0) begin e_m = q0.pop_front(); have_e = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e_m = q1.pop_front(); have_e = 1'b1; end
            if (!have_e) begin
              chk($sformatf("unexpected_done_d%0d", d), 32'd1, 32'd0);
            end else begin
              chk($sformatf("pass_d%0d", d), 32'(pass_o[d]), 32'(e_m.pass));
              chk($sformatf("pat_cnt_d%0d", d), 32'(cnt_o[d]), 32'(N));
              chk($sformatf("tpg_en_cycles_d%0d", d), 32'(en_cnt[d]), 32'(N));
              chk($sformatf("misr_shift_cycles_d%0d", d), 32'(sh_cnt[d]), 32'(N));
              chk($sformatf("shift_lag_d%0d", d), 32'(first_sh[d] - first_en[d]), 32'(lat_of(d)));
              // SEED + N patterns + latency drain + CHECK
              chk($sformatf("done_latency_d%0d", d), 32'(cyc - seed_cyc[d]), 32'(N + lat_of(d) + 2));
`ifdef BIST_SIG_CAPTURE_EN
              chk($sformatf("sig_cap_d%0d", d), 32'(cap_o[d]), 32'(e_m.sig));
`endif
            end
          end
          done_prev[d] = done_o[d];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s0, s1;
    int         hold, k, w;
    exp_t       e;

    dp0.sig = 8'h00;
    dp1.sig = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset", 1'b1);
    reset_b = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 30; r++) begin
      s0 = pick_sig(G0);
      s1 = pick_sig(G1);
      dp0.sig = s0;
      dp1.sig = s1;
      start = 1'b1;
      if (r % 4 == 2) begin
        @(negedge clk);
        start = 1'b0;
        k = $urandom_range(0, 4);
        repeat (k) @(negedge clk);
        abort = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk_quiet($sformatf("abort_r%0d", r), 1'b0);
      end else begin
        e.pass = (s0 == G0); e.sig = s0; q0.push_back(e);
        e.pass = (s1 == G1); e.sig = s1; q1.push_back(e);
        hold = $urandom_range(1, 3);
        repeat (hold) @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(done0 && done1) && w < 40) begin
          @(negedge clk);
          w++;
        end
        chk($sformatf("done_seen_r%0d", r), 32'(done0 & done1), 32'd1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // asynchronous reset in the middle of RUN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_b = 1'b0;
    #1 chk_quiet("reset_mid_run", 1'b1);
    @(negedge clk);
    reset_b = 1'b1;
    repeat (12) @(negedge clk);

    chk("scoreboard0_empty", 32'(q0.size()), 32'd0);
    chk("scoreboard1_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
